// File: rtl/mix_columns_seq_pkg.sv
// Shared AES types, FSM encoding and the GF(2^8) doubling helper for the
// MixColumns sequencer.
package aes_pkg;

    typedef logic [7:0]   byte_t;
    typedef byte_t [3:0]  col_t;
    typedef logic [127:0] state_t;

    typedef enum logic [1:0] {
        MCS_IDLE,
        MCS_RUN,
        MCS_DONE
    } mcs_state_e;

    localparam int unsigned NUM_COLS = 4;
    localparam byte_t       AES_POLY = 8'h1B;

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1
    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/mix_columns_seq_if.sv
// Valid/ready handshake bundle for mix_columns_seq. bypass_i exists only when
// MIXCOL_BYPASS_EN is defined.
interface mix_columns_seq_if;

    logic                in_valid_i;
    logic                in_ready_o;
    aes_pkg::state_t     in_data_i;
    logic                out_valid_o;
    logic                out_ready_i;
    aes_pkg::state_t     out_data_o;
    logic                busy_o;
`ifdef MIXCOL_BYPASS_EN
    logic                bypass_i;
`endif

    modport slave (
        input  in_valid_i,
        output in_ready_o,
        input  in_data_i,
        output out_valid_o,
        input  out_ready_i,
        output out_data_o,
`ifdef MIXCOL_BYPASS_EN
        input  bypass_i,
`endif
        output busy_o
    );

    modport master (
        output in_valid_i,
        input  in_ready_o,
        output in_data_i,
        input  out_valid_o,
        output out_ready_i,
        input  out_data_o,
`ifdef MIXCOL_BYPASS_EN
        output bypass_i,
`endif
        input  busy_o
    );

endinterface

// File: rtl/mix_columns_seq_col.sv
// Single-column AES MixColumns unit. Index 3 holds row 0, index 0 holds row 3.
module mixColumns_col
    import aes_pkg::*;
(
    input  col_t col_i,
    output col_t col_o
);

    byte_t x0, x1, x2, x3;

    assign x0 = xtime(col_i[0]);
    assign x1 = xtime(col_i[1]);
    assign x2 = xtime(col_i[2]);
    assign x3 = xtime(col_i[3]);

    // out_row r = 2*a_r ^ 3*a_{r+1} ^ a_{r+2} ^ a_{r+3}, with row r at index 3-r
    assign col_o[3] = x3 ^ x2 ^ col_i[2] ^ col_i[1] ^ col_i[0];
    assign col_o[2] = x2 ^ x1 ^ col_i[1] ^ col_i[0] ^ col_i[3];
    assign col_o[1] = x1 ^ x0 ^ col_i[0] ^ col_i[3] ^ col_i[2];
    assign col_o[0] = x0 ^ x3 ^ col_i[3] ^ col_i[2] ^ col_i[1];

endmodule

// File: rtl/mix_columns_seq.sv
// Time-shared AES MixColumns over a 128-bit state, COLS_PER_CYCLE columns per
// cycle. Optional pass-through for the final round under MIXCOL_BYPASS_EN.
module mix_columns_seq
    import aes_pkg::*;
#(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    mix_columns_seq_if.slave  bus
);

    localparam logic [1:0] LAST_IDX = 2'(NUM_COLS - COLS_PER_CYCLE);
    localparam logic [1:0] IDX_STEP = 2'(COLS_PER_CYCLE);

    mcs_state_e fsm;
    logic [1:0] col_idx;
    state_t     state_q;
    state_t     run_next;
    logic       accept;
    logic       mix_off;

    col_t cur_cols  [NUM_COLS];
    col_t next_cols [NUM_COLS];
    col_t mixed     [COLS_PER_CYCLE];

`ifdef MIXCOL_BYPASS_EN
    logic bypass_q;
    assign mix_off = bypass_q;
`else
    assign mix_off = 1'b0;
`endif

    assign bus.in_ready_o  = (fsm == MCS_IDLE) || ((fsm == MCS_DONE) && bus.out_ready_i);
    assign bus.out_valid_o = (fsm == MCS_DONE);
    assign bus.busy_o      = (fsm == MCS_RUN);
    assign bus.out_data_o  = state_q;
    assign accept          = bus.in_valid_i && bus.in_ready_o;

    always_comb begin
        for (int unsigned c = 0; c < NUM_COLS; c++) begin
            cur_cols[c] = state_q[127 - 32*c -: 32];
        end
    end

    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
        mixColumns_col u_col (
            .col_i (cur_cols[col_idx + 2'(g)]),
            .col_o (mixed[g])
        );
    end

    // Only the current column group is replaced; the rest write back unchanged
    always_comb begin
        next_cols = cur_cols;
        run_next  = state_q;
        for (int unsigned g = 0; g < COLS_PER_CYCLE; g++) begin
            next_cols[col_idx + 2'(g)] = mixed[g];
        end
        if (!mix_off) begin
            for (int unsigned c = 0; c < NUM_COLS; c++) begin
                run_next[127 - 32*c -: 32] = next_cols[c];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm      <= MCS_IDLE;
            col_idx  <= '0;
            state_q  <= '0;
`ifdef MIXCOL_BYPASS_EN
            bypass_q <= 1'b0;
`endif
        end else begin
            case (fsm)
                MCS_IDLE: begin
                    if (accept) begin
                        fsm      <= MCS_RUN;
                        col_idx  <= '0;
                        state_q  <= bus.in_data_i;
`ifdef MIXCOL_BYPASS_EN
                        bypass_q <= bus.bypass_i;
`endif
                    end
                end
                MCS_RUN: begin
                    state_q <= run_next;
                    if (col_idx == LAST_IDX) begin
                        fsm     <= MCS_DONE;
                        col_idx <= '0;
                    end else begin
                        col_idx <= col_idx + IDX_STEP;
                    end
                end
                MCS_DONE: begin
                    if (bus.out_ready_i) begin
                        if (accept) begin
                            fsm      <= MCS_RUN;
                            col_idx  <= '0;
                            state_q  <= bus.in_data_i;
`ifdef MIXCOL_BYPASS_EN
                            bypass_q <= bus.bypass_i;
`endif
                        end else begin
                            fsm <= MCS_IDLE;
                        end
                    end
                end
                default: fsm <= MCS_IDLE;
            endcase
        end
    end

endmodule
